// File: rtl/rf_safe_shutdown.sv
// rtl/rf_safe_shutdown.sv - watchdog-driven RF amplitude gate with ramped shutdown and sticky fault
module rf_safe_shutdown #(
  parameter int unsigned       AMP_W      = 16,
  parameter int unsigned       RAMP_DIV   = 4,
  parameter logic [AMP_W-1:0]  STEP       = 16'h1000,
  parameter int unsigned       WARN_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wd_triggered,
  input  logic             wd_warning,
  input  logic             rf_enable_req,
  input  logic             fault_clear,
  input  logic [AMP_W-1:0] amp_target,
  output logic [AMP_W-1:0] amp_out,
  output logic             rf_enable,
  output logic             fault_latched,
  output logic             wd_force_reset,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AMP_W-1:0] amp_q;
  logic             rf_en_q;
  logic             fault_q;
  logic             frst_q;

  logic             tick_d;
  logic [AMP_W-1:0] tgt_d;
  logic [AMP_W:0]   sum_d;
  logic [AMP_W-1:0] amp_up_d;
  logic [AMP_W-1:0] amp_dn_d;

  // Ramp arithmetic: warning-attenuated target, saturating up step, floored down step
  always_comb begin
    tick_d   = (cnt_q == CNT_LAST);
    tgt_d    = wd_warning ? (amp_target >> WARN_SHIFT) : amp_target;
    sum_d    = {1'b0, amp_q} + {1'b0, STEP};
    amp_up_d = (sum_d > {1'b0, tgt_d}) ? tgt_d : sum_d[AMP_W-1:0];
    amp_dn_d = (amp_q <= STEP) ? '0 : (amp_q - STEP);
  end

  // Control FSM with registered amplitude, enable, fault flag and watchdog re-arm pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      amp_q   <= '0;
      rf_en_q <= 1'b0;
      fault_q <= 1'b0;
      frst_q  <= 1'b0;
    end else begin
      frst_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          amp_q   <= '0;
          rf_en_q <= 1'b0;
          cnt_q   <= '0;
          if (wd_triggered) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else if (rf_enable_req) begin
            state_q <= RAMP_UP;
            rf_en_q <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (wd_triggered) begin
            state_q <= RAMP_DOWN;
            fault_q <= 1'b1;
            cnt_q   <= '0;
          end else if (!rf_enable_req) begin
            state_q <= RAMP_DOWN;
            cnt_q   <= '0;
          end else if (tick_d) begin
            amp_q <= amp_up_d;
            cnt_q <= '0;
            if (amp_up_d == tgt_d) state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          cnt_q <= '0;
          if (wd_triggered) begin
            state_q <= RAMP_DOWN;
            fault_q <= 1'b1;
          end else if (!rf_enable_req) begin
            state_q <= RAMP_DOWN;
          end else begin
            amp_q <= tgt_d;
          end
        end
        RAMP_DOWN: begin
          // A late trigger still forces the fault path once the carrier is off
          if (wd_triggered) fault_q <= 1'b1;
          if (amp_q == '0) begin
            state_q <= (fault_q || wd_triggered) ? FAULT : IDLE;
            rf_en_q <= 1'b0;
            cnt_q   <= '0;
          end else if (tick_d) begin
            amp_q <= amp_dn_d;
            cnt_q <= '0;
            if (amp_dn_d == '0) begin
              state_q <= (fault_q || wd_triggered) ? FAULT : IDLE;
              rf_en_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        FAULT: begin
          amp_q   <= '0;
          rf_en_q <= 1'b0;
          cnt_q   <= '0;
          fault_q <= 1'b1;
          if (fault_clear && !wd_triggered) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
            frst_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          amp_q   <= '0;
          rf_en_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign amp_out        = amp_q;
  assign rf_enable      = rf_en_q;
  assign fault_latched  = fault_q;
  assign wd_force_reset = frst_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_rf_safe_shutdown.sv
// tb/tb_rf_safe_shutdown.sv - self-checking bench for rf_safe_shutdown
module tb_rf_safe_shutdown;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wd_triggered;
  logic        wd_warning;
  logic        rf_enable_req;
  logic        fault_clear;
  logic [15:0] amp_target;
  logic [15:0] amp_out;
  logic        rf_enable;
  logic        fault_latched;
  logic        wd_force_reset;
  logic [2:0]  state_out;

  typedef struct {
    int          cyc;
    logic [15:0] amp;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  rf_safe_shutdown #(
    .AMP_W(16), .RAMP_DIV(4), .STEP(16'h1000), .WARN_SHIFT(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wd_triggered(wd_triggered), .wd_warning(wd_warning),
    .rf_enable_req(rf_enable_req), .fault_clear(fault_clear),
    .amp_target(amp_target), .amp_out(amp_out), .rf_enable(rf_enable),
    .fault_latched(fault_latched), .wd_force_reset(wd_force_reset),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wd_triggered = 1'b0; wd_warning = 1'b0;
    rf_enable_req = 1'b0; fault_clear = 1'b0; amp_target = 16'h0000;
    step(); step();
    chk_cnt++; if (amp_out !== 16'h0) $display("FAIL reset_amp got %h want 0000", amp_out); else pass_cnt++;
    chk_cnt++; if (rf_enable !== 1'b0) $display("FAIL reset_rf got %b want 0", rf_enable); else pass_cnt++;
    chk_cnt++; if (fault_latched !== 1'b0) $display("FAIL reset_fault got %b want 0", fault_latched); else pass_cnt++;
    chk_cnt++; if (wd_force_reset !== 1'b0) $display("FAIL reset_frst got %b want 0", wd_force_reset); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL reset_state got %0d want 0", state_out); else pass_cnt++;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_ramp_up();
    exp_t e;
    amp_target = 16'h4000;
    rf_enable_req = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back('{cyc: 4 * k + 1, amp: 16'(16'h1000 * k)});
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) begin
        chk_cnt++; if (rf_enable !== 1'b1) $display("FAIL ramp_up_rf_en got %b want 1", rf_enable); else pass_cnt++;
      end
      if (c == 16) begin
        chk_cnt++; if (state_out !== 3'd1) $display("FAIL ramp_up_state16 got %0d want 1", state_out); else pass_cnt++;
      end
      if (c == 17) begin
        chk_cnt++; if (state_out !== 3'd2) $display("FAIL ramp_up_state17 got %0d want 2", state_out); else pass_cnt++;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        chk_cnt++; if (amp_out !== e.amp) $display("FAIL ramp_up_amp cyc %0d got %h want %h", c, amp_out, e.amp); else pass_cnt++;
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL ramp_up_drain got %0d left want 0", exp_q.size()); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_warning();
    wd_warning = 1'b1;
    step();
    chk_cnt++; if (amp_out !== 16'h2000) $display("FAIL warn_on_amp got %h want 2000", amp_out); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd2) $display("FAIL warn_on_state got %0d want 2", state_out); else pass_cnt++;
    wd_warning = 1'b0;
    step();
    chk_cnt++; if (amp_out !== 16'h4000) $display("FAIL warn_off_amp got %h want 4000", amp_out); else pass_cnt++;
  endtask

  task automatic test_timeout();
    exp_t e;
    wd_triggered = 1'b1;
    step();
    wd_triggered = 1'b0;
    chk_cnt++; if (fault_latched !== 1'b1) $display("FAIL timeout_fault got %b want 1", fault_latched); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd3) $display("FAIL timeout_state got %0d want 3", state_out); else pass_cnt++;
    chk_cnt++; if (amp_out !== 16'h4000) $display("FAIL timeout_hold got %h want 4000", amp_out); else pass_cnt++;
    exp_q.push_back('{cyc: 5,  amp: 16'h3000});
    exp_q.push_back('{cyc: 9,  amp: 16'h2000});
    exp_q.push_back('{cyc: 13, amp: 16'h1000});
    exp_q.push_back('{cyc: 17, amp: 16'h0000});
    for (int c = 2; c <= 22; c++) begin
      step();
      if (c == 16) begin
        chk_cnt++; if (rf_enable !== 1'b1) $display("FAIL timeout_rf16 got %b want 1", rf_enable); else pass_cnt++;
      end
      if (c == 17 || c == 22) begin
        chk_cnt++; if (state_out !== 3'd4) $display("FAIL timeout_fault_state cyc %0d got %0d want 4", c, state_out); else pass_cnt++;
        chk_cnt++; if (rf_enable !== 1'b0) $display("FAIL timeout_rf_off cyc %0d got %b want 0", c, rf_enable); else pass_cnt++;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        chk_cnt++; if (amp_out !== e.amp) $display("FAIL timeout_amp cyc %0d got %h want %h", c, amp_out, e.amp); else pass_cnt++;
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL timeout_drain got %0d left want 0", exp_q.size()); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_fault_clear();
    wd_triggered = 1'b1;
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    chk_cnt++; if (wd_force_reset !== 1'b0) $display("FAIL clear_blocked_frst got %b want 0", wd_force_reset); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd4) $display("FAIL clear_blocked_state got %0d want 4", state_out); else pass_cnt++;
    chk_cnt++; if (fault_latched !== 1'b1) $display("FAIL clear_blocked_fault got %b want 1", fault_latched); else pass_cnt++;
    wd_triggered = 1'b0;
    rf_enable_req = 1'b0;
    step();
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    chk_cnt++; if (wd_force_reset !== 1'b1) $display("FAIL clear_frst got %b want 1", wd_force_reset); else pass_cnt++;
    chk_cnt++; if (fault_latched !== 1'b0) $display("FAIL clear_fault got %b want 0", fault_latched); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL clear_state got %0d want 0", state_out); else pass_cnt++;
    step();
    chk_cnt++; if (wd_force_reset !== 1'b0) $display("FAIL clear_frst_width got %b want 0", wd_force_reset); else pass_cnt++;
  endtask

  task automatic test_graceful_stop();
    exp_t e;
    int   n;
    amp_target = 16'h2000;
    rf_enable_req = 1'b1;
    n = 0;
    while (state_out !== 3'd2 && n < 40) begin step(); n++; end
    chk_cnt++; if (state_out !== 3'd2 || amp_out !== 16'h2000) $display("FAIL stop_reach_run got st %0d amp %h want 2/2000", state_out, amp_out); else pass_cnt++;
    rf_enable_req = 1'b0;
    exp_q.push_back('{cyc: 5, amp: 16'h1000});
    exp_q.push_back('{cyc: 9, amp: 16'h0000});
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin
        chk_cnt++; if (state_out !== 3'd3) $display("FAIL stop_state1 got %0d want 3", state_out); else pass_cnt++;
      end
      if (c == 9) begin
        chk_cnt++; if (state_out !== 3'd0 || rf_enable !== 1'b0) $display("FAIL stop_idle got st %0d rf %b want 0/0", state_out, rf_enable); else pass_cnt++;
      end
      if (c == 10) begin
        chk_cnt++; if (fault_latched !== 1'b0) $display("FAIL stop_fault got %b want 0", fault_latched); else pass_cnt++;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        e = exp_q.pop_front();
        chk_cnt++; if (amp_out !== e.amp) $display("FAIL stop_amp cyc %0d got %h want %h", c, amp_out, e.amp); else pass_cnt++;
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL stop_drain got %0d left want 0", exp_q.size()); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_target_zero();
    int n;
    amp_target = 16'h0000;
    rf_enable_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 4) begin
        chk_cnt++; if (state_out !== 3'd1) $display("FAIL zero_state4 got %0d want 1", state_out); else pass_cnt++;
      end
      if (c == 5) begin
        chk_cnt++; if (state_out !== 3'd2 || amp_out !== 16'h0) $display("FAIL zero_run got st %0d amp %h want 2/0000", state_out, amp_out); else pass_cnt++;
      end
    end
    rf_enable_req = 1'b0;
    n = 0;
    step();
    while (state_out !== 3'd0 && n < 8) begin step(); n++; end
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL zero_idle got %0d want 0", state_out); else pass_cnt++;
  endtask

  task automatic test_trig_with_drop();
    int n;
    amp_target = 16'h4000;
    rf_enable_req = 1'b1;
    for (int c = 1; c <= 6; c++) step();
    rf_enable_req = 1'b0;
    wd_triggered = 1'b1;
    step();
    wd_triggered = 1'b0;
    chk_cnt++; if (state_out !== 3'd3 || fault_latched !== 1'b1) $display("FAIL trigdrop got st %0d fault %b want 3/1", state_out, fault_latched); else pass_cnt++;
    n = 0;
    while (state_out !== 3'd4 && n < 30) begin step(); n++; end
    chk_cnt++; if (state_out !== 3'd4 || amp_out !== 16'h0) $display("FAIL trigdrop_fault got st %0d amp %h want 4/0000", state_out, amp_out); else pass_cnt++;
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL trigdrop_clear got %0d want 0", state_out); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    amp_target = 16'h4000;
    rf_enable_req = 1'b1;
    for (int c = 1; c <= 9; c++) step();
    chk_cnt++; if (amp_out !== 16'h2000 || state_out !== 3'd1) $display("FAIL arst_pre got amp %h st %0d want 2000/1", amp_out, state_out); else pass_cnt++;
    #2;
    rstn = 1'b0;
    #1;
    chk_cnt++; if (amp_out !== 16'h0) $display("FAIL arst_amp got %h want 0000", amp_out); else pass_cnt++;
    chk_cnt++; if (rf_enable !== 1'b0) $display("FAIL arst_rf got %b want 0", rf_enable); else pass_cnt++;
    chk_cnt++; if (state_out !== 3'd0) $display("FAIL arst_state got %0d want 0", state_out); else pass_cnt++;
    rf_enable_req = 1'b0;
    step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_warning();
    test_timeout();
    test_fault_clear();
    test_graceful_stop();
    test_target_zero();
    test_trig_with_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
